// File: rtl/freq_bcd_conv.sv
// freq_bcd_conv: serial double-dabble binary-to-BCD converter for a frequency counter display.
module freq_bcd_conv #(
  parameter int IN_WIDTH = 32,
  parameter int DIGITS   = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [IN_WIDTH-1:0]   i_count,
  input  logic                  i_count_valid,
  input  logic                  i_signal_detect,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [DIGITS-1:0]     o_blank,
  output logic [3:0]            o_digits,
  output logic                  o_no_signal,
  output logic                  o_bcd_valid,
  output logic                  o_busy,
  output logic                  o_overrun
);
  localparam int CW = $clog2(IN_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t                state_q, state_d;
  logic [IN_WIDTH-1:0]   sr_q, sr_d;
  logic [4*DIGITS-1:0]   acc_q, acc_d, adj;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  det_q, det_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0]     blank_q, blank_d, blank_c;
  logic [3:0]            digits_q, digits_d, msd;
  logic                  nosig_q, nosig_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;
  always_comb begin
    adj = '0;
    msd = '0;
    blank_c = '0;
    for (int d = 0; d < DIGITS; d++) begin
      adj[4*d+:4] = (acc_q[4*d+:4] >= 4'd5) ? acc_q[4*d+:4] + 4'd3 : acc_q[4*d+:4];
      if (acc_q[4*d+:4] != 4'd0) msd = 4'(d);
    end
    for (int d = 0; d < DIGITS; d++) blank_c[d] = 4'(d) > msd;
  end
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    det_d    = det_q;
    bcd_d    = bcd_q;
    blank_d  = blank_q;
    digits_d = digits_q;
    nosig_d  = nosig_q;
    valid_d  = 1'b0;
    ovr_d    = i_count_valid && (state_q != IDLE);
    case (state_q)
      IDLE: if (i_count_valid) begin
        sr_d    = i_count;
        acc_d   = '0;
        det_d   = i_signal_detect;
        cnt_d   = CW'(IN_WIDTH);
        state_d = SHIFT;
      end
      SHIFT: begin
        {acc_d, sr_d} = {adj, sr_q} << 1;
        cnt_d         = cnt_q - 1'b1;
        state_d       = (cnt_q == CW'(1)) ? DONE : SHIFT;
      end
      DONE: begin
        bcd_d    = acc_q;
        blank_d  = blank_c;
        digits_d = msd + 4'd1;
        nosig_d  = !det_q;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      det_q    <= 1'b0;
      bcd_q    <= '0;
      blank_q  <= {{(DIGITS-1){1'b1}}, 1'b0};
      digits_q <= 4'd1;
      nosig_q  <= 1'b1;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      det_q    <= det_d;
      bcd_q    <= bcd_d;
      blank_q  <= blank_d;
      digits_q <= digits_d;
      nosig_q  <= nosig_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end
  assign o_bcd       = bcd_q;
  assign o_blank     = blank_q;
  assign o_digits    = digits_q;
  assign o_no_signal = nosig_q;
  assign o_bcd_valid = valid_q;
  assign o_busy      = state_q != IDLE;
  assign o_overrun   = ovr_q;
endmodule

// File: tb/tb_freq_bcd_conv.sv
// tb_freq_bcd_conv: table-driven conversion vectors plus overrun, DONE-cycle and reset sequences.
module tb_freq_bcd_conv;
  logic clk = 0, rst = 0, cv = 0, det = 0;
  logic [31:0] cnt_i = 0;
  logic [39:0] bcd;
  logic [9:0]  blank;
  logic [3:0]  digits;
  logic        nosig, bv, busy, ovr;
  int checks = 0, errors = 0, cyc = 0, nv = 0, no = 0, lat;
  logic [39:0] vb[$];
  int          vc[$];
  always #5 clk = ~clk;
  freq_bcd_conv dut (
    .i_clk(clk), .i_rst(rst), .i_count(cnt_i), .i_count_valid(cv), .i_signal_detect(det),
    .o_bcd(bcd), .o_blank(blank), .o_digits(digits), .o_no_signal(nosig),
    .o_bcd_valid(bv), .o_busy(busy), .o_overrun(ovr)
  );
  always @(posedge clk) begin
    cyc++;
    #2;
    if (bv) begin
      nv++;
      vb.push_back(bcd);
      vc.push_back(cyc);
    end
    if (ovr) no++;
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic strobe(input logic [31:0] c, input logic d);
    @(negedge clk);
    cnt_i = c;
    det = d;
    cv = 1;
    @(negedge clk);
    cv = 0;
  endtask
  task automatic run(input logic [31:0] c, input logic d, output int l);
    @(negedge clk);
    cnt_i = c;
    det = d;
    cv = 1;
    @(posedge clk);
    #1;
    cv = 0;
    chk("busy_after_accept", busy, 1);
    l = 0;
    while (!bv && l < 50) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask
  task automatic clear_mon();
    nv = 0;
    no = 0;
    vb.delete();
    vc.delete();
  endtask
  typedef struct {
    logic [31:0] c;
    logic        d;
    logic [39:0] b;
    logic [9:0]  bl;
    logic [3:0]  n;
  } vec_t;
  vec_t v[9];
  initial begin
    v[0] = '{32'd0,          1'b0, 40'h0000000000, 10'h3FE, 4'd1};
    v[1] = '{32'd25_000_000, 1'b1, 40'h0025000000, 10'h300, 4'd8};
    v[2] = '{32'hFFFF_FFFF,  1'b1, 40'h4294967295, 10'h000, 4'd10};
    v[3] = '{32'd1234,       1'b1, 40'h0000001234, 10'h3F0, 4'd4};
    v[4] = '{32'd7,          1'b1, 40'h0000000007, 10'h3FE, 4'd1};
    v[5] = '{32'd10,         1'b0, 40'h0000000010, 10'h3FC, 4'd2};
    v[6] = '{32'd99999,      1'b1, 40'h0000099999, 10'h3E0, 4'd5};
    v[7] = '{32'd1_000_000_000, 1'b1, 40'h1000000000, 10'h000, 4'd10};
    v[8] = '{32'd9,          1'b0, 40'h0000000009, 10'h3FE, 4'd1};
    #1 rst = 1;
    #11;
    chk("rst_bcd", bcd, 0);
    chk("rst_blank", blank, 10'h3FE);
    chk("rst_digits", digits, 1);
    chk("rst_nosig", nosig, 1);
    chk("rst_valid", bv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", ovr, 0);
    @(negedge clk) rst = 0;
    for (int i = 0; i < 9; i++) begin
      run(v[i].c, v[i].d, lat);
      chk("latency", lat, 33);
      chk("bcd", bcd, v[i].b);
      chk("blank", blank, v[i].bl);
      chk("digits", digits, v[i].n);
      chk("no_signal", nosig, !v[i].d);
      @(posedge clk);
      #1;
      chk("valid_one_cycle", bv, 0);
      chk("bcd_hold", bcd, v[i].b);
      chk("busy_idle", busy, 0);
    end
    clear_mon();
    strobe(32'd1234, 1);
    repeat (3) @(negedge clk);
    strobe(32'd9999, 1);
    repeat (40) @(negedge clk);
    chk("ovr_pulses", no, 1);
    chk("ovr_valids", nv, 1);
    if (vb.size() > 0) chk("ovr_result", vb[0], 40'h1234);
    chk("ovr_digits", digits, 4);
    clear_mon();
    strobe(32'd55, 1);
    repeat (32) @(negedge clk);
    chk("done_busy", busy, 1);
    cnt_i = 32'd9;
    cv = 1;
    @(negedge clk);
    cnt_i = 32'd77;
    @(negedge clk);
    cv = 0;
    repeat (40) @(negedge clk);
    chk("done_ovr_pulses", no, 1);
    chk("done_valids", nv, 2);
    if (vb.size() > 1) begin
      chk("done_first", vb[0], 40'h55);
      chk("done_second", vb[1], 40'h77);
      chk("done_spacing", vc[1] - vc[0], 34);
    end
    clear_mon();
    strobe(32'd1234, 1);
    repeat (9) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("arst_bcd", bcd, 0);
    chk("arst_blank", blank, 10'h3FE);
    chk("arst_digits", digits, 1);
    chk("arst_nosig", nosig, 1);
    chk("arst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (40) @(negedge clk);
    chk("arst_no_valid", nv, 0);
    run(32'd7, 1, lat);
    chk("post_rst_latency", lat, 33);
    chk("post_rst_bcd", bcd, 40'h7);
    chk("post_rst_digits", digits, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
